// File: rtl/barrett_red_stage.sv
// Multi-cycle Barrett reduction: y = x mod q for x < q^2, one result every 6 cycles.
// Optional `BARRETT_RED_ERR_CHECK_EN adds an err output flagging an incomplete final correction.
`timescale 1ns/1ps
module barrett_red_stage #(
    parameter int NBITS = 128,
    parameter int PBITS = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_p,
    input  logic [2*NBITS-1:0] x,
    input  logic [NBITS-1:0]   q,
    input  logic [NBITS:0]     mu,
    output logic [NBITS-1:0]   y,
    output logic               done,
    output logic               busy
`ifdef BARRETT_RED_ERR_CHECK_EN
    ,
    output logic               err
`endif
);

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, SUB, COR1, COR2} state_t;

    state_t               state_q, state_d;
    logic [2*NBITS-1:0]   x_q, x_d;
    logic [NBITS-1:0]     q_q, q_d;
    logic [NBITS:0]       mu_q, mu_d;
    logic [NBITS:0]       q3_q, q3_d;
    logic [NBITS:0]       p2_q, p2_d;
    logic [NBITS:0]       r_q, r_d;
    logic [NBITS-1:0]     y_q, y_d;
    logic                 done_q, done_d;
`ifdef BARRETT_RED_ERR_CHECK_EN
    logic                 err_q, err_d;
`endif

    logic [NBITS:0]       q1;
    logic [2*NBITS+1:0]   p1;
    logic [NBITS:0]       q_ext;
    logic [NBITS:0]       r_corr;

    // PBITS is reserved for product-width trimming and has no functional effect.
    if (PBITS < 0) begin : g_pbits_reserved
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        q_d     = q_q;
        mu_d    = mu_q;
        q3_d    = q3_q;
        p2_d    = p2_q;
        r_d     = r_q;
        y_d     = y_q;
        done_d  = 1'b0;
`ifdef BARRETT_RED_ERR_CHECK_EN
        err_d   = err_q;
`endif

        q1     = (NBITS+1)'(x_q >> (NBITS-1));
        p1     = {{(NBITS+1){1'b0}}, q1} * {{(NBITS+1){1'b0}}, mu_q};
        q_ext  = {1'b0, q_q};
        r_corr = (r_q >= q_ext) ? (r_q - q_ext) : r_q;

        case (state_q)
            IDLE: begin
                if (enable_p) begin
                    x_d     = x;
                    q_d     = q;
                    mu_d    = mu;
                    state_d = MUL1;
                end
            end
            MUL1: begin
                // Only p1 >> (NBITS+1) is ever consumed, so that slice is what gets stored.
                q3_d    = (NBITS+1)'(p1 >> (NBITS+1));
                state_d = MUL2;
            end
            MUL2: begin
                p2_d    = q3_q * q_ext;
                state_d = SUB;
            end
            SUB: begin
                r_d     = x_q[NBITS:0] - p2_q;
                state_d = COR1;
            end
            COR1: begin
                r_d     = r_corr;
                state_d = COR2;
            end
            COR2: begin
                r_d     = r_corr;
                y_d     = r_corr[NBITS-1:0];
                done_d  = 1'b1;
`ifdef BARRETT_RED_ERR_CHECK_EN
                err_d   = (r_corr >= q_ext);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            q_q     <= '0;
            mu_q    <= '0;
            q3_q    <= '0;
            p2_q    <= '0;
            r_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
`ifdef BARRETT_RED_ERR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            q_q     <= q_d;
            mu_q    <= mu_d;
            q3_q    <= q3_d;
            p2_q    <= p2_d;
            r_q     <= r_d;
            y_q     <= y_d;
            done_q  <= done_d;
`ifdef BARRETT_RED_ERR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign y    = y_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);
`ifdef BARRETT_RED_ERR_CHECK_EN
    assign err  = err_q;
`endif

endmodule

// File: tb/tb_barrett_red_stage.sv
// Directed bench for barrett_red_stage at NBITS=8, q=251, mu=261 (err test needs BARRETT_RED_ERR_CHECK_EN).
`timescale 1ns/1ps
module tb_barrett_red_stage;
    localparam int NBITS = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable_p = 1'b0;
    logic [2*NBITS-1:0] x_in = '0;
    logic [NBITS-1:0]   q_in = 8'd251;
    logic [NBITS:0]     mu_in = 9'd261;
    logic [NBITS-1:0]   y;
    logic               done;
    logic               busy;
`ifdef BARRETT_RED_ERR_CHECK_EN
    logic               err;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    barrett_red_stage #(.NBITS(NBITS), .PBITS(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_p (enable_p),
        .x        (x_in),
        .q        (q_in),
        .mu       (mu_in),
        .y        (y),
        .done     (done),
        .busy     (busy)
`ifdef BARRETT_RED_ERR_CHECK_EN
        ,
        .err      (err)
`endif
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Drive enable_p for one cycle (cycle 0); returns at the sample point of cycle 1.
    task automatic start_op(input logic [2*NBITS-1:0] xv);
        @(negedge clk);
        enable_p = 1'b1;
        x_in     = xv;
        @(negedge clk);
        enable_p = 1'b0;
        x_in     = 16'($urandom_range(0, 65535));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (y !== 8'd0) begin failures++; $display("FAIL reset_y got=%0d want=0", y); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
`ifdef BARRETT_RED_ERR_CHECK_EN
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic want_busy, want_done;
        start_op(16'd62500);
        for (int c = 1; c <= 8; c++) begin
            want_busy = (c <= 5);
            want_done = (c == 6);
            checks++;
            if (busy !== want_busy) begin failures++; $display("FAIL latency_busy cycle=%0d got=%b want=%b", c, busy, want_busy); end
            checks++;
            if (done !== want_done) begin failures++; $display("FAIL latency_done cycle=%0d got=%b want=%b", c, done, want_done); end
            if (c >= 6) begin
                checks++;
                if (y !== 8'd1) begin failures++; $display("FAIL latency_y cycle=%0d got=%0d want=1", c, y); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] xs [3];
        logic [7:0]  ys [3];
        logic [5:0]  dv;
        xs = '{16'd1000, 16'd0, 16'd50200};
        ys = '{8'd247, 8'd0, 8'd0};
        for (int i = 0; i < 3; i++) begin
            start_op(xs[i]);
            dv = '0;
            for (int c = 1; c <= 6; c++) begin
                dv[c-1] = done;
                if (c < 6) @(negedge clk);
            end
            checks++;
            if (dv !== 6'b100000) begin failures++; $display("FAIL vec_done x=%0d got=%b want=100000", xs[i], dv); end
            checks++;
            if (y !== ys[i]) begin failures++; $display("FAIL vec_y x=%0d got=%0d want=%0d", xs[i], y, ys[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore();
        int ndone;
        int first;
        ndone = 0;
        first = 0;
        start_op(16'd1000);
        for (int c = 1; c <= 12; c++) begin
            if (done) begin
                ndone++;
                if (first == 0) first = c;
            end
            if (c == 3) begin
                enable_p = 1'b1;
                x_in     = 16'd0;
            end
            if (c == 4) enable_p = 1'b0;
            @(negedge clk);
        end
        checks++; if (ndone != 1) begin failures++; $display("FAIL ignore_count got=%0d want=1", ndone); end
        checks++; if (first != 6) begin failures++; $display("FAIL ignore_cycle got=%0d want=6", first); end
        checks++; if (y !== 8'd247) begin failures++; $display("FAIL ignore_y got=%0d want=247", y); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] dv;
        start_op(16'd1000);
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b want=1", done); end
        checks++; if (y !== 8'd247) begin failures++; $display("FAIL b2b_y1 got=%0d want=247", y); end
        enable_p = 1'b1;
        x_in     = 16'd62500;
        @(negedge clk);
        enable_p = 1'b0;
        x_in     = 16'($urandom_range(0, 65535));
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b want=1", busy); end
        dv = '0;
        for (int c = 7; c <= 12; c++) begin
            dv[c-7] = done;
            if (c < 12) begin
                checks++;
                if (y !== 8'd247) begin failures++; $display("FAIL b2b_hold cycle=%0d got=%0d want=247", c, y); end
                @(negedge clk);
            end
        end
        checks++; if (dv !== 6'b100000) begin failures++; $display("FAIL b2b_done2 got=%b want=100000", dv); end
        checks++; if (y !== 8'd1) begin failures++; $display("FAIL b2b_y2 got=%0d want=1", y); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int ndone;
        start_op(16'd1000);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (y !== 8'd0) begin failures++; $display("FAIL abort_y got=%0d want=0", y); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b want=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (10) begin
            if (done) ndone++;
            @(negedge clk);
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", ndone); end
        start_op(16'd62500);
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL abort_restart_done got=%b want=1", done); end
        checks++; if (y !== 8'd1) begin failures++; $display("FAIL abort_restart_y got=%0d want=1", y); end
        @(negedge clk);
    endtask

`ifdef BARRETT_RED_ERR_CHECK_EN
    task automatic test_err_check();
        q_in  = 8'd128;
        mu_in = 9'd0;
        start_op(16'd511);
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL err_done got=%b want=1", done); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=1", err); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_hold got=%b want=1", err); end
        q_in  = 8'd251;
        mu_in = 9'd261;
        start_op(16'd1000);
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL err_done2 got=%b want=1", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want=0", err); end
        checks++; if (y !== 8'd247) begin failures++; $display("FAIL err_y2 got=%0d want=247", y); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_ignore();
        test_back_to_back();
        test_reset_abort();
`ifdef BARRETT_RED_ERR_CHECK_EN
        test_err_check();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
